ifu_fetch: RTL and testbench

- Instruction-fetch sequencer directly upstream of the ITCM controller.
- Owns the fetch PC and issues read commands on the ifu2itcm cmd channel. Accepts in-order responses on the ifu2itcm rsp channel and buffers fetched instructions, each tagged with its PC, in a small FIFO for decode.
- Handles redirect (branch/flush) by discarding buffered and in-flight fetches and restarting at a new PC.

---
 rtl/ifu_fetch_if.sv | 38 +++
 rtl/ifu_fetch.sv | 104 ++++++++++
 tb/tb_ifu_fetch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-side bundle: ITCM command/response channels plus the decode-facing instruction port.
// Every channel transfers on a cycle where valid & ready are both high; valid never waits on ready.
interface ifu_fetch_if #(
    parameter int PC_W    = 32,
    parameter int ITCM_AW = 16,
    parameter int ITCM_DW = 32,
    parameter int ITCM_MW = 4
);
    logic               ifu2itcm_cmd_valid;
    logic               ifu2itcm_cmd_ready;
    logic               ifu2itcm_cmd_read;
    logic [ITCM_AW-1:0] ifu2itcm_cmd_addr;
    logic [ITCM_MW-1:0] ifu2itcm_cmd_wmask;
    logic [ITCM_DW-1:0] ifu2itcm_cmd_wdata;
    logic               ifu2itcm_rsp_valid;
    logic               ifu2itcm_rsp_ready;
    logic [ITCM_DW-1:0] ifu2itcm_rsp_rdata;
    logic               ifu_o_valid;
    logic               ifu_o_ready;
    logic [ITCM_DW-1:0] ifu_o_ir;
    logic [PC_W-1:0]    ifu_o_pc;

    modport master (
        output ifu2itcm_cmd_valid, ifu2itcm_cmd_read, ifu2itcm_cmd_addr,
        output ifu2itcm_cmd_wmask, ifu2itcm_cmd_wdata, ifu2itcm_rsp_ready,
        input  ifu2itcm_cmd_ready, ifu2itcm_rsp_valid, ifu2itcm_rsp_rdata,
        output ifu_o_valid, ifu_o_ir, ifu_o_pc,
        input  ifu_o_ready
    );

    modport slave (
        input  ifu2itcm_cmd_valid, ifu2itcm_cmd_read, ifu2itcm_cmd_addr,
        input  ifu2itcm_cmd_wmask, ifu2itcm_cmd_wdata, ifu2itcm_rsp_ready,
        output ifu2itcm_cmd_ready, ifu2itcm_rsp_valid, ifu2itcm_rsp_rdata,
        input  ifu_o_valid, ifu_o_ir, ifu_o_pc,
        output ifu_o_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch sequencer: owns the PC, issues credit-limited ITCM reads and
// buffers PC-tagged instructions for decode; redirect flushes and restarts fetch.
module ifu_fetch #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              ITCM_AW  = 16,
    parameter int              ITCM_DW  = 32,
    parameter int              ITCM_MW  = 4,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    ifu_fetch_if.master     bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]    r_pc;
    logic [CW-1:0]      r_fifo_cnt;
    logic [CW-1:0]      r_out;
    logic [CW-1:0]      r_drop;
    logic [PW-1:0]      r_wptr, r_rptr, r_twptr, r_trptr;
    logic [ITCM_DW-1:0] r_fifo_ir [DEPTH];
    logic [PC_W-1:0]    r_fifo_pc [DEPTH];
    logic [PC_W-1:0]    r_tag     [DEPTH];

    logic [CW:0]        w_credit_sum;
    logic               w_cmd_valid, w_issue, w_rsp_acc, w_keep, w_pop, w_fifo_valid;
    logic [PC_W-1:0]    w_tag;
    logic [CW-1:0]      w_out_next;
    logic               w_unused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count buffered plus in-flight entries, so every response has a FIFO slot.
    assign w_credit_sum = {1'b0, r_fifo_cnt} + {1'b0, r_out};
    assign w_cmd_valid  = fetch_en & ~redirect_valid & ~rst & (w_credit_sum < (CW+1)'(DEPTH));
    assign w_issue      = w_cmd_valid & bus.ifu2itcm_cmd_ready;
    assign w_rsp_acc    = bus.ifu2itcm_rsp_valid & ~rst & ((r_out != '0) | w_issue);
    // An empty tag queue means the response belongs to this cycle's command.
    assign w_tag        = (r_out == '0) ? r_pc : r_tag[r_trptr];
    assign w_keep       = w_rsp_acc & (r_drop == '0) & ~redirect_valid;
    assign w_fifo_valid = (r_fifo_cnt != '0);
    assign w_pop        = w_fifo_valid & bus.ifu_o_ready & ~redirect_valid;
    assign w_out_next   = r_out + CW'(w_issue) - CW'(w_rsp_acc);

    assign bus.ifu2itcm_cmd_valid = w_cmd_valid;
    assign bus.ifu2itcm_cmd_read  = 1'b1;
    assign bus.ifu2itcm_cmd_addr  = r_pc[ITCM_AW+1:2];
    assign bus.ifu2itcm_cmd_wmask = '0;
    assign bus.ifu2itcm_cmd_wdata = '0;
    assign bus.ifu2itcm_rsp_ready = 1'b1;
    assign bus.ifu_o_valid        = w_fifo_valid;
    assign bus.ifu_o_ir           = w_fifo_valid ? r_fifo_ir[r_rptr] : '0;
    assign bus.ifu_o_pc           = w_fifo_valid ? r_fifo_pc[r_rptr] : '0;

    assign w_unused = ^{redirect_pc[1:0], r_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_fifo_cnt <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_twptr    <= '0;
            r_trptr    <= '0;
        end else begin
            r_out <= w_out_next;
            if (w_rsp_acc) r_trptr <= ptr_inc(r_trptr);
            if (redirect_valid) begin
                // Tags of in-flight commands stay queued so dropped responses still pop in order.
                r_pc       <= {redirect_pc[PC_W-1:2], 2'b00};
                r_fifo_cnt <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_drop     <= w_out_next;
            end else begin
                if (w_issue) begin
                    r_pc    <= r_pc + PC_W'(4);
                    r_twptr <= ptr_inc(r_twptr);
                end
                if (w_rsp_acc && (r_drop != '0)) r_drop <= r_drop - 1'b1;
                if (w_keep) r_wptr <= ptr_inc(r_wptr);
                if (w_pop)  r_rptr <= ptr_inc(r_rptr);
                r_fifo_cnt <= r_fifo_cnt + CW'(w_keep) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_tag[r_twptr] <= r_pc;
        if (w_keep) begin
            r_fifo_ir[r_wptr] <= bus.ifu2itcm_rsp_rdata;
            r_fifo_pc[r_wptr] <= w_tag;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle-accurate vector table, directed redirect/reset sequences,
// and an in-order scoreboard of {ir, pc} fed by observed command handshakes.
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        lat2;
    logic [1:0]  pipe_v;
    logic [15:0] pipe_a [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_pc;
    logic [63:0] exp_q[$];

    ifu_fetch_if #(.PC_W(32), .ITCM_AW(16), .ITCM_DW(32), .ITCM_MW(4)) bus ();

    ifu_fetch #(.PC_W(32), .RESET_PC(32'h0), .ITCM_AW(16), .ITCM_DW(32), .ITCM_MW(4), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A5A_0F0F;
    endfunction

    // ITCM model: zero latency (combinational) or two-cycle registered latency.
    always_comb begin
        if (!lat2) begin
            bus.ifu2itcm_rsp_valid = bus.ifu2itcm_cmd_valid & bus.ifu2itcm_cmd_ready;
            bus.ifu2itcm_rsp_rdata = mem_word(bus.ifu2itcm_cmd_addr);
        end else begin
            bus.ifu2itcm_rsp_valid = pipe_v[1];
            bus.ifu2itcm_rsp_rdata = mem_word(pipe_a[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= lat2 & bus.ifu2itcm_cmd_valid & bus.ifu2itcm_cmd_ready;
            pipe_a[0] <= bus.ifu2itcm_cmd_addr;
            pipe_v[1] <= pipe_v[0];
            pipe_a[1] <= pipe_a[0];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on command handshake, pop on decode handshake, flush on redirect/reset.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_pc = 32'h0;
        end else begin
            if (bus.ifu_o_valid && bus.ifu_o_ready && !redirect_valid) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    chk("sb_ir_pc", {bus.ifu_o_ir, bus.ifu_o_pc}, exp_q.pop_front());
            end
            if (bus.ifu2itcm_cmd_valid && bus.ifu2itcm_cmd_ready) begin
                chk("sb_cmd_addr", 64'(bus.ifu2itcm_cmd_addr), 64'(model_pc[17:2]));
                exp_q.push_back({mem_word(model_pc[17:2]), model_pc});
                model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    typedef struct {
        logic        fe, rdy, cr;
        logic        exp_cv;
        logic [15:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl [16];

    task automatic wait_ov(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.ifu_o_valid) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({name, "_seen"}, 64'(found), 64'd1);
        if (found) begin
            chk({name, "_pc"}, 64'(bus.ifu_o_pc), 64'(exp_pc));
            chk({name, "_ir"}, 64'(bus.ifu_o_ir), 64'(mem_word(exp_pc[17:2])));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        bit hit;
        // fe rdy cr | cv addr ov pc
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 32'h04};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 32'h08};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 32'h08};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 32'h08};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd4, 1'b1, 32'h08};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd4, 1'b1, 32'h0C};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd5, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd6, 1'b1, 32'h14};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd6, 1'b0, 32'h00};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd6, 1'b0, 32'h00};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd6, 1'b0, 32'h00};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd7, 1'b1, 32'h18};

        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat2 = 1'b0;
        bus.ifu2itcm_cmd_ready = 1'b1; bus.ifu_o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", 64'(bus.ifu2itcm_cmd_valid), 64'd0);
        chk("rst_o_valid",   64'(bus.ifu_o_valid), 64'd0);
        chk("rst_o_ir",      64'(bus.ifu_o_ir), 64'd0);
        chk("rst_o_pc",      64'(bus.ifu_o_pc), 64'd0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            fetch_en = tbl[i].fe; bus.ifu_o_ready = tbl[i].rdy; bus.ifu2itcm_cmd_ready = tbl[i].cr;
            @(negedge clk);
            chk($sformatf("t%0d_cmd_valid", i), 64'(bus.ifu2itcm_cmd_valid), 64'(tbl[i].exp_cv));
            chk($sformatf("t%0d_cmd_addr", i),  64'(bus.ifu2itcm_cmd_addr),  64'(tbl[i].exp_addr));
            chk($sformatf("t%0d_o_valid", i),   64'(bus.ifu_o_valid),        64'(tbl[i].exp_ov));
            if (tbl[i].exp_ov)
                chk($sformatf("t%0d_o_pc", i), 64'(bus.ifu_o_pc), 64'(tbl[i].exp_pc));
            next_cycle();
        end

        // Drain, then switch to the 2-cycle ITCM and redirect with two fetches in flight.
        fetch_en = 1'b0;
        repeat (6) next_cycle();
        lat2 = 1'b1; fetch_en = 1'b1;
        @(negedge clk);
        chk("lat_a_cmd_addr", 64'(bus.ifu2itcm_cmd_addr), 64'd8);
        next_cycle();
        @(negedge clk);
        chk("lat_b_cmd_valid", 64'(bus.ifu2itcm_cmd_valid), 64'd1);
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("redir_cmd_valid", 64'(bus.ifu2itcm_cmd_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_next_cv",   64'(bus.ifu2itcm_cmd_valid), 64'd1);
        chk("redir_next_addr", 64'(bus.ifu2itcm_cmd_addr), 64'h40);
        chk("redir_next_ov",   64'(bus.ifu_o_valid), 64'd0);
        next_cycle();
        wait_ov("redir_first", 32'h100);
        next_cycle();
        wait_ov("redir_second", 32'h104);

        // Redirect on a cycle that also has a decode handshake and an ITCM response.
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            next_cycle();
            if (bus.ifu_o_valid && bus.ifu2itcm_rsp_valid) begin
                hit = 1;
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
            end
        end
        chk("coll_found", 64'(hit), 64'd1);
        @(negedge clk);
        chk("coll_cmd_valid", 64'(bus.ifu2itcm_cmd_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coll_o_valid",  64'(bus.ifu_o_valid), 64'd0);
        chk("coll_cmd_cv",   64'(bus.ifu2itcm_cmd_valid), 64'd1);
        chk("coll_cmd_addr", 64'(bus.ifu2itcm_cmd_addr), 64'h80);
        next_cycle();
        wait_ov("coll_first", 32'h200);

        // Fill the FIFO, then reset mid-stream.
        next_cycle();
        bus.ifu_o_ready = 1'b0;
        repeat (12) next_cycle();
        @(negedge clk);
        chk("full_o_valid", 64'(bus.ifu_o_valid), 64'd1);
        chk("full_o_pc",    64'(bus.ifu_o_pc), 64'h204);
        chk("full_cmd_cv",  64'(bus.ifu2itcm_cmd_valid), 64'd0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cv", 64'(bus.ifu2itcm_cmd_valid), 64'd0);
        next_cycle();
        lat2 = 1'b0;
        @(negedge clk);
        chk("mid_rst_ov", 64'(bus.ifu_o_valid), 64'd0);
        chk("mid_rst_cv2", 64'(bus.ifu2itcm_cmd_valid), 64'd0);
        chk("mid_rst_pc", 64'(bus.ifu_o_pc), 64'd0);
        next_cycle();
        rst = 1'b0; bus.ifu_o_ready = 1'b1; fetch_en = 1'b1;
        @(negedge clk);
        chk("restart_cv",   64'(bus.ifu2itcm_cmd_valid), 64'd1);
        chk("restart_addr", 64'(bus.ifu2itcm_cmd_addr), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("restart_ov", 64'(bus.ifu_o_valid), 64'd1);
        chk("restart_pc", 64'(bus.ifu_o_pc), 64'd0);

        // PC wrap from the top of the address space.
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_redir_cv", 64'(bus.ifu2itcm_cmd_valid), 64'd0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr_top", 64'(bus.ifu2itcm_cmd_addr), 64'hFFFF);
        next_cycle();
        @(negedge clk);
        chk("wrap_addr_zero", 64'(bus.ifu2itcm_cmd_addr), 64'd0);
        chk("wrap_o_pc_top",  64'(bus.ifu_o_pc), 64'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        chk("wrap_o_pc_zero", 64'(bus.ifu_o_pc), 64'd0);
        chk("wrap_o_valid",   64'(bus.ifu_o_valid), 64'd1);
        next_cycle();
        fetch_en = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
